// File: rtl/blink_rate_scheduler.sv
// blink_rate_scheduler
//   Generates a blink period whose length is chosen by a 3-bit speed level.
//   A prescaler divides clk into base ticks; the period is (8 - level) * 4
//   base ticks. blink_tick pulses in the last cycle of each period and phase
//   toggles on every blink_tick.
//
// Parameters
//   PRESCALE    : clk cycles per base tick (2 .. 2^24)
//   RESET_LEVEL : speed level loaded at reset (0 .. 7)
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   enable     : 1 runs the timing counters, 0 freezes them
//   restart    : one-cycle pulse, resynchronises timing to period start
//   up / down  : one-cycle pulses, saturating increment / decrement of level
//   blink_tick : one-cycle pulse at the end of each blink period
//   phase      : square wave, toggles on every blink_tick
//   level      : current registered speed level
module blink_rate_scheduler #(
    parameter int unsigned PRESCALE    = 3125000,
    parameter int unsigned RESET_LEVEL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       restart,
    input  logic       up,
    input  logic       down,
    output logic       blink_tick,
    output logic       phase,
    output logic [2:0] level
);

    localparam int unsigned PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [2:0]    RST_LVL = 3'(RESET_LEVEL);

    // Period in base ticks for a level: (8 - l) * 4, range 4..32.
    function automatic logic [5:0] period_of(input logic [2:0] l);
        return {4'd8 - {1'b0, l}, 2'b00};
    endfunction

    logic [PW-1:0] pre_cnt;
    logic [4:0]    per_cnt;
    logic [5:0]    active_period;
    logic [2:0]    level_next;
    logic          base_tick;

    always_comb begin
        level_next = level;
        if (up && !down && level != 3'd7)
            level_next = level + 3'd1;
        else if (down && !up && level != 3'd0)
            level_next = level - 3'd1;
    end

    // reset and restart both suppress the end-of-period pulse in their cycle.
    always_comb begin
        base_tick  = enable && (pre_cnt == PRE_MAX);
        blink_tick = base_tick && !reset && !restart &&
                     ({1'b0, per_cnt} == active_period - 6'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level         <= RST_LVL;
            pre_cnt       <= '0;
            per_cnt       <= '0;
            phase         <= 1'b0;
            active_period <= period_of(RST_LVL);
        end else begin
            level <= level_next;
            if (restart) begin
                // Period comes from the pre-update level, so a coincident
                // up/down only affects the period after this one.
                pre_cnt       <= '0;
                per_cnt       <= '0;
                phase         <= 1'b0;
                active_period <= period_of(level);
            end else if (enable) begin
                pre_cnt <= base_tick ? '0 : pre_cnt + PW'(1);
                if (blink_tick) begin
                    per_cnt       <= '0;
                    phase         <= ~phase;
                    active_period <= period_of(level);
                end else if (base_tick) begin
                    per_cnt <= per_cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_blink_rate_scheduler.sv
module tb_blink_rate_scheduler;

    localparam int P  = 4;
    localparam int RL = 4;

    logic       clk = 1'b0;
    logic       reset, enable, restart, up, down;
    logic       blink_tick, phase;
    logic [2:0] level;

    blink_rate_scheduler #(.PRESCALE(P), .RESET_LEVEL(RL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .up(up), .down(down), .blink_tick(blink_tick), .phase(phase),
        .level(level)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: time kept as enabled cycles elapsed in the period.
    int m_level   = RL;
    int m_active  = P * (8 - RL) * 4;
    int m_elapsed = 0;
    bit m_phase   = 1'b0;
    int since     = 0;   // cycles since last reset release

    // Per-cycle observation / expectation
    logic obs_tick, obs_phase;
    logic [2:0] obs_level;
    logic exp_tick, exp_phase;
    logic [2:0] exp_level;
    int idx;

    task automatic cycle(input logic r, rs, en, u, d);
        int nl;
        reset = r; restart = rs; enable = en; up = u; down = d;
        @(negedge clk);
        obs_tick = blink_tick; obs_phase = phase; obs_level = level;
        exp_tick  = !r && !rs && en && (m_elapsed == m_active - 1);
        exp_phase = m_phase;
        exp_level = 3'(m_level);
        idx = since;
        @(posedge clk);
        #1;
        if (r) begin
            m_level = RL; m_elapsed = 0; m_phase = 1'b0;
            m_active = P * (8 - RL) * 4; since = 0;
        end else begin
            nl = m_level;
            if (u && !d)      nl = (m_level < 7) ? m_level + 1 : 7;
            else if (d && !u) nl = (m_level > 0) ? m_level - 1 : 0;
            if (rs) begin
                m_elapsed = 0; m_phase = 1'b0; m_active = P * (8 - m_level) * 4;
            end else if (en) begin
                if (exp_tick) begin
                    m_elapsed = 0; m_phase = !m_phase; m_active = P * (8 - m_level) * 4;
                end else begin
                    m_elapsed++;
                end
            end
            m_level = nl;
            since++;
        end
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 0);
        n_cmp++;
        if ({obs_tick, obs_phase, obs_level} !== {exp_tick, exp_phase, exp_level}) begin
            n_fail++;
            $display("FAIL reset_hold got tick/phase/level=%b/%b/%0d exp=%b/%b/%0d",
                     obs_tick, obs_phase, obs_level, exp_tick, exp_phase, exp_level);
        end
        cycle(0, 0, 0, 0, 0);
        n_cmp++;
        if ({obs_tick, obs_phase, obs_level} !== {1'b0, 1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL reset_state got tick/phase/level=%b/%b/%0d exp=0/0/4",
                     obs_tick, obs_phase, obs_level);
        end
    endtask

    task automatic test_default_period();
        int ticks[$];
        bit ph_after;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            cycle(0, 0, 1, 0, 0);
            n_cmp++;
            if ({obs_tick, obs_phase, obs_level} !== {exp_tick, exp_phase, exp_level}) begin
                n_fail++;
                $display("FAIL default_period idx=%0d got %b/%b/%0d exp %b/%b/%0d",
                         idx, obs_tick, obs_phase, obs_level, exp_tick, exp_phase, exp_level);
            end
            if (obs_tick) ticks.push_back(idx);
            if (idx == 64) ph_after = obs_phase;
        end
        n_cmp++;
        if (ticks.size() < 2 || ticks[0] != 63 || ticks[1] != 127) begin
            n_fail++;
            $display("FAIL default_tick_times got n=%0d first=%0d second=%0d exp 63/127",
                     ticks.size(), ticks.size() > 0 ? ticks[0] : -1,
                     ticks.size() > 1 ? ticks[1] : -1);
        end
        n_cmp++;
        if (ph_after !== 1'b1) begin
            n_fail++;
            $display("FAIL default_phase_toggle got %b exp 1", ph_after);
        end
    endtask

    task automatic test_saturation();
        int ticks[$];
        int n;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, (i % 2) == 0, 0);
            n_cmp++;
            if ({obs_tick, obs_phase, obs_level} !== {exp_tick, exp_phase, exp_level}) begin
                n_fail++;
                $display("FAIL sat_up idx=%0d got %b/%b/%0d exp %b/%b/%0d",
                         idx, obs_tick, obs_phase, obs_level, exp_tick, exp_phase, exp_level);
            end
        end
        for (int i = 0; i < 140; i++) begin
            cycle(0, 0, 1, 0, 0);
            n_cmp++;
            if ({obs_tick, obs_phase, obs_level} !== {exp_tick, exp_phase, exp_level}) begin
                n_fail++;
                $display("FAIL sat_up_run idx=%0d got %b/%b/%0d exp %b/%b/%0d",
                         idx, obs_tick, obs_phase, obs_level, exp_tick, exp_phase, exp_level);
            end
            if (obs_tick) ticks.push_back(idx);
        end
        n_cmp++;
        if (obs_level !== 3'd7 || ticks.size() < 2 || ticks[0] != 63 || ticks[1] - ticks[0] != 16) begin
            n_fail++;
            $display("FAIL sat_up_period got level=%0d n=%0d first=%0d exp level=7 first=63 interval=16",
                     obs_level, ticks.size(), ticks.size() > 0 ? ticks[0] : -1);
        end
        ticks.delete();
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 0, (i % 2) == 0);
            n_cmp++;
            if ({obs_tick, obs_phase, obs_level} !== {exp_tick, exp_phase, exp_level}) begin
                n_fail++;
                $display("FAIL sat_down idx=%0d got %b/%b/%0d exp %b/%b/%0d",
                         idx, obs_tick, obs_phase, obs_level, exp_tick, exp_phase, exp_level);
            end
        end
        for (int i = 0; i < 420; i++) begin
            cycle(0, 0, 1, 0, 0);
            n_cmp++;
            if ({obs_tick, obs_phase, obs_level} !== {exp_tick, exp_phase, exp_level}) begin
                n_fail++;
                $display("FAIL sat_down_run idx=%0d got %b/%b/%0d exp %b/%b/%0d",
                         idx, obs_tick, obs_phase, obs_level, exp_tick, exp_phase, exp_level);
            end
            if (obs_tick) ticks.push_back(idx);
        end
        n = ticks.size();
        n_cmp++;
        if (obs_level !== 3'd0 || n < 3 || ticks[n-1] - ticks[n-2] != 128) begin
            n_fail++;
            $display("FAIL sat_down_period got level=%0d n=%0d exp level=0 interval=128",
                     obs_level, n);
        end
    endtask

    task automatic test_up_down_same();
        logic [2:0] seq_lvl [4];
        do_reset();
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 0, 0);
        seq_lvl[0] = obs_level;
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);   // 4 -> 0, then one more
        cycle(0, 0, 0, 0, 0);
        seq_lvl[1] = obs_level;
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0);   // 0 -> 7, then one more
        cycle(0, 0, 0, 0, 0);
        seq_lvl[2] = obs_level;
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);
        seq_lvl[3] = obs_level;
        n_cmp++;
        if ({seq_lvl[0], seq_lvl[1], seq_lvl[2], seq_lvl[3]} !== {3'd4, 3'd0, 3'd7, 3'd7}) begin
            n_fail++;
            $display("FAIL up_down_same got %0d/%0d/%0d/%0d exp 4/0/7/7",
                     seq_lvl[0], seq_lvl[1], seq_lvl[2], seq_lvl[3]);
        end
    endtask

    task automatic test_enable_freeze();
        int first;
        first = -1;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            cycle(0, 0, !(i >= 20 && i < 30), 0, 0);
            n_cmp++;
            if ({obs_tick, obs_phase, obs_level} !== {exp_tick, exp_phase, exp_level}) begin
                n_fail++;
                $display("FAIL enable_freeze idx=%0d got %b/%b/%0d exp %b/%b/%0d",
                         idx, obs_tick, obs_phase, obs_level, exp_tick, exp_phase, exp_level);
            end
            if (obs_tick && first < 0) first = idx;
        end
        n_cmp++;
        if (first != 73) begin
            n_fail++;
            $display("FAIL enable_freeze_delay got first tick at %0d exp 73", first);
        end
    endtask

    task automatic test_restart_up();
        int ticks[$];
        int r_idx;
        logic ph1;
        logic [2:0] lv1;
        do_reset();
        for (int i = 0; i < 100; i++) cycle(0, 0, 1, 0, 0);   // phase now 1
        cycle(0, 1, 1, 1, 0);
        r_idx = idx;
        n_cmp++;
        if (obs_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_no_tick got %b exp 0", obs_tick);
        end
        cycle(0, 0, 1, 0, 0);
        ph1 = obs_phase; lv1 = obs_level;
        n_cmp++;
        if ({ph1, lv1} !== {1'b0, 3'd5}) begin
            n_fail++;
            $display("FAIL restart_state got phase/level=%b/%0d exp 0/5", ph1, lv1);
        end
        for (int i = 0; i < 200; i++) begin
            cycle(0, 0, 1, 0, 0);
            n_cmp++;
            if ({obs_tick, obs_phase, obs_level} !== {exp_tick, exp_phase, exp_level}) begin
                n_fail++;
                $display("FAIL restart_run idx=%0d got %b/%b/%0d exp %b/%b/%0d",
                         idx, obs_tick, obs_phase, obs_level, exp_tick, exp_phase, exp_level);
            end
            if (obs_tick) ticks.push_back(idx);
        end
        n_cmp++;
        if (ticks.size() < 2 || ticks[0] != r_idx + 64 || ticks[1] - ticks[0] != 48) begin
            n_fail++;
            $display("FAIL restart_period got n=%0d first=%0d exp first=%0d interval=48",
                     ticks.size(), ticks.size() > 0 ? ticks[0] : -1, r_idx + 64);
        end
    endtask

    task automatic test_reset_mid();
        int first;
        first = -1;
        do_reset();
        for (int i = 0; i < 90; i++) cycle(0, 0, 1, (i == 10), 0);
        cycle(1, 0, 1, 1, 0);
        n_cmp++;
        if (obs_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_tick got %b exp 0", obs_tick);
        end
        cycle(0, 0, 1, 0, 0);
        n_cmp++;
        if ({obs_phase, obs_level} !== {1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL reset_mid_state got phase/level=%b/%0d exp 0/4", obs_phase, obs_level);
        end
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 1, 0, 0);
            if (obs_tick && first < 0) first = idx;
        end
        n_cmp++;
        if (first != 63) begin
            n_fail++;
            $display("FAIL reset_mid_period got first tick at %0d exp 63", first);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(999) < 3, $urandom_range(99) < 2,
                  $urandom_range(99) < 90, $urandom_range(99) < 3,
                  $urandom_range(99) < 3);
            n_cmp++;
            if ({obs_tick, obs_phase, obs_level} !== {exp_tick, exp_phase, exp_level}) begin
                n_fail++;
                $display("FAIL random i=%0d got %b/%b/%0d exp %b/%b/%0d",
                         i, obs_tick, obs_phase, obs_level, exp_tick, exp_phase, exp_level);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; restart = 1'b0; up = 1'b0; down = 1'b0;
        test_reset();
        test_default_period();
        test_saturation();
        test_up_down_same();
        test_enable_freeze();
        test_restart_up();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_rate_scheduler.md
BLINK_RATE_SCHEDULER -- requirements
Module: blink_rate_scheduler

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 3125000, meaning clk cycles per base tick (1/32 s at 100 MHz); legal range 2..2^24.
REQ-002 The block SHALL have parameter RESET_LEVEL, default 4, meaning the speed level loaded at reset; legal range 0..7.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit; 1 lets the timing counters run, 0 freezes them.
REQ-006 The block SHALL have port restart, input, 1 bit, a one-cycle pulse that resynchronises the timing to period start.
REQ-007 The block SHALL have port up, input, 1 bit, a one-cycle pulse that increments the speed level.
REQ-008 The block SHALL have port down, input, 1 bit, a one-cycle pulse that decrements the speed level.
REQ-009 The block SHALL have port blink_tick, output, 1 bit, a one-cycle pulse at the end of each blink period.
REQ-010 The block SHALL have port phase, output, 1 bit, a square wave that toggles on every blink_tick.
REQ-011 The block SHALL have port level, output, 3 bits, the current registered speed level.

Function
REQ-012 The block SHALL hold level in a 3-bit register, updated one cycle after an up or down pulse.
REQ-013 An up pulse alone SHALL increment level, saturating at 7.
REQ-014 A down pulse alone SHALL decrement level, saturating at 0.
REQ-015 up and down asserted in the same cycle SHALL leave level unchanged.
REQ-016 up and down SHALL be honoured regardless of enable.
REQ-017 The period for a given level SHALL be (8 - level) * 4 base ticks: level 0 gives 32, level 7 gives 4.
REQ-018 The active period SHALL be latched from the registered level only at reset, at restart, and in the cycle blink_tick is asserted.
REQ-019 A level change mid-period SHALL take effect from the next period, never truncating or extending the current one.
REQ-020 The prescale counter SHALL count 0..PRESCALE-1 while enable=1 and wrap to 0.
REQ-021 base_tick (internal) SHALL be asserted in the cycle the prescale counter equals PRESCALE-1 and enable=1.
REQ-022 The period counter SHALL advance on each base_tick through 0..active_period-1 and wrap to 0.
REQ-023 blink_tick SHALL be asserted, combinationally from registered state, exactly in the cycle where base_tick=1 and the period counter equals active_period-1.
REQ-024 phase SHALL toggle on the clock edge that ends a blink_tick cycle.
REQ-025 While enable=0, the prescale counter, period counter and phase SHALL hold their values and blink_tick SHALL be 0.
REQ-026 A restart SHALL clear both counters, set phase=0, deassert blink_tick in that cycle, and latch the active period from the pre-update level.
REQ-027 An up or down pulse in the same cycle as restart SHALL still update level, but that update SHALL NOT affect the period latched by the restart.
REQ-028 Priority SHALL be reset > restart > enable/counting.
REQ-029 After a restart with enable=1, the first blink_tick SHALL occur exactly PRESCALE * period cycles after the restart cycle.

Reset
REQ-030 With reset=1 at a clock edge, level SHALL become RESET_LEVEL, the counters 0, phase 0, the active period (8 - RESET_LEVEL) * 4, and blink_tick 0 in every cycle reset is high.
REQ-031 Reset SHALL override all other inputs, including an up, down or restart pulse in the same cycle.
REQ-032 Reset SHALL NOT depend on any asynchronous path.

Verification (PRESCALE=4, RESET_LEVEL=4)
REQ-033 Reset, then enable=1 -> blink_tick every 64 cycles, first at cycle 63 after reset release, and phase toggles each time.
REQ-034 Eight up pulses -> level saturates at 7, and the period becomes 16 cycles starting only after the current period ends; eight down pulses -> level=0 and a 128-cycle period.
REQ-035 up and down in the same cycle -> level unchanged; a down pulse at level 0 or an up pulse at level 7 -> level unchanged.
REQ-036 enable=0 for 10 cycles mid-period -> blink_tick is delayed by exactly 10 cycles and phase holds.
REQ-037 restart plus up in the same cycle at level 4 -> level=5, the next blink_tick 64 cycles later, then 48-cycle periods, with phase=0 immediately after restart.
REQ-038 Reset asserted mid-period together with an up pulse -> level=4, phase=0, no blink_tick, and a clean 64-cycle period after reset release.
